// File: rtl/aes_subbytes_serial_pkg.sv
// -----------------------------------------------------------------------------
// aes_subbytes_serial_pkg
// Shared types, constants and GF arithmetic for the serial SubBytes stage.
//
// Tower field: GF(2^8) = GF(2^4)[y] / (y^2 + y + TOWER_LAMBDA), where
// GF(2^4) = GF(2)[x] / (x^4 + x + 1). A tower byte is {hi, lo} = hi*y + lo.
//
// The two basis-change matrices are derived at elaboration time. A root
// beta of the AES polynomial z^8+z^4+z^3+z+1 is found inside the tower
// field. The AES power z^i then maps to beta^i, which fixes
// MAP_TO_TOWER column by column. AFFINE_FROM_TOWER is the inverse of that
// map followed by the linear part of the AES affine transform. Rows of a
// bv8_mat_t are bit masks: y[r] = ^(m[r] & x).
// -----------------------------------------------------------------------------
package aes_subbytes_serial_pkg;

  typedef logic [3:0]      bv4_t;
  typedef logic [7:0]      bv8_t;
  typedef logic [127:0]    bv128_t;
  typedef logic [7:0][7:0] bv8_mat_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} subbytes_state_e;

  localparam bv8_t       SBOX_CONST   = 8'h63;
  localparam logic [4:0] GF4_POLY     = 5'b10011;  // x^4 + x + 1
  localparam bv4_t       TOWER_LAMBDA = 4'hC;      // trace 1, so y^2+y+lambda is irreducible

  // GF(2^4) multiply, reduced modulo GF4_POLY.
  function automatic bv4_t gf4_mul(input bv4_t a, input bv4_t b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (7'(a) << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (7'(GF4_POLY) << (i - 4));
    return p[3:0];
  endfunction

  // GF(2^4) inverse as a^14 (a^-1 = a^(2^4-2)); 0 maps to 0.
  function automatic bv4_t gf4_inv(input bv4_t a);
    bv4_t a2, a4, a8;
    a2 = gf4_mul(a, a);
    a4 = gf4_mul(a2, a2);
    a8 = gf4_mul(a4, a4);
    return gf4_mul(gf4_mul(a2, a4), a8);
  endfunction

  // Multiply in the tower field: y^2 = y + lambda.
  function automatic bv8_t tower_mul(input bv8_t a, input bv8_t b);
    bv4_t hh;
    hh = gf4_mul(a[7:4], b[7:4]);
    return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
            gf4_mul(hh, TOWER_LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
  endfunction

  // Matrix-vector product over GF(2).
  function automatic bv8_t gf2_mat_vec(input bv8_mat_t m, input bv8_t x);
    bv8_t y;
    for (int r = 0; r < 8; r++) y[r] = ^(m[r] & x);
    return y;
  endfunction

  // Linear part of the AES affine transform (constant 0x63 added separately).
  function automatic bv8_t aes_affine_lin(input bv8_t x);
    bv8_t       y;
    logic [2:0] k;
    for (int r = 0; r < 8; r++) begin
      k    = 3'(r);
      y[r] = x[k] ^ x[3'(k + 3'd4)] ^ x[3'(k + 3'd5)] ^ x[3'(k + 3'd6)] ^ x[3'(k + 3'd7)];
    end
    return y;
  endfunction

  // Smallest tower element that is a root of the AES field polynomial.
  function automatic bv8_t find_tower_root();
    bv8_t pows [9];
    bv8_t root;
    logic found;
    root  = 8'h00;
    found = 1'b0;
    for (int cand = 2; cand < 256; cand++) begin
      pows[0] = 8'h01;
      for (int i = 1; i < 9; i++) pows[i] = tower_mul(pows[i-1], 8'(cand));
      if (!found && ((pows[8] ^ pows[4] ^ pows[3] ^ pows[1] ^ pows[0]) == 8'h00)) begin
        root  = 8'(cand);
        found = 1'b1;
      end
    end
    return root;
  endfunction

  function automatic bv8_mat_t calc_map_to_tower();
    bv8_mat_t m;
    bv8_t     beta, p;
    beta = find_tower_root();
    p    = 8'h01;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) m[r][c] = p[r];
      p = tower_mul(p, beta);
    end
    return m;
  endfunction

  // Column c is affine_lin(a_c), where a_c is the AES byte whose tower image is e_c.
  function automatic bv8_mat_t calc_affine_from_tower();
    bv8_mat_t m2t, m;
    bv8_t     t, col;
    m2t = calc_map_to_tower();
    m   = '0;
    for (int a = 0; a < 256; a++) begin
      t = gf2_mat_vec(m2t, 8'(a));
      for (int c = 0; c < 8; c++) begin
        if (t == (8'h01 << c)) begin
          col = aes_affine_lin(8'(a));
          for (int r = 0; r < 8; r++) m[r][c] = col[r];
        end
      end
    end
    return m;
  endfunction

  localparam bv8_mat_t MAP_TO_TOWER      = calc_map_to_tower();
  localparam bv8_mat_t AFFINE_FROM_TOWER = calc_affine_from_tower();

endpackage

// File: rtl/aes_subbytes_serial_sbox.sv
// -----------------------------------------------------------------------------
// bv8_inv  : GF(2^8) inverter in the tower basis, 0 maps to 0.
//   i_x    in  8  tower-basis operand {hi, lo}
//   o_inv  out 8  tower-basis inverse
// aes_sbox : combinational AES S-box lane built around bv8_inv.
//   i_byte in  8  AES byte
//   o_byte out 8  S(i_byte)
// -----------------------------------------------------------------------------
module bv8_inv
  import aes_subbytes_serial_pkg::*;
(
  input  bv8_t i_x,
  output bv8_t o_inv
);

  bv4_t w_hi, w_lo, w_sum, w_norm, w_norm_inv;

  assign w_hi  = i_x[7:4];
  assign w_lo  = i_x[3:0];
  assign w_sum = w_hi ^ w_lo;

  // (hi*y + lo)(hi*y + hi + lo) = lambda*hi^2 + lo*(hi + lo), which lies in GF(2^4).
  // Its inverse scales the conjugate into the inverse.
  assign w_norm     = gf4_mul(gf4_mul(w_hi, w_hi), TOWER_LAMBDA) ^ gf4_mul(w_lo, w_sum);
  assign w_norm_inv = gf4_inv(w_norm);
  assign o_inv      = {gf4_mul(w_hi, w_norm_inv), gf4_mul(w_sum, w_norm_inv)};

endmodule

module aes_sbox
  import aes_subbytes_serial_pkg::*;
(
  input  bv8_t i_byte,
  output bv8_t o_byte
);

  bv8_t w_tower, w_inv;

  assign w_tower = gf2_mat_vec(MAP_TO_TOWER, i_byte);

  bv8_inv u_inv (
    .i_x   (w_tower),
    .o_inv (w_inv)
  );

  assign o_byte = gf2_mat_vec(AFFINE_FROM_TOWER, w_inv) ^ SBOX_CONST;

endmodule

// File: rtl/aes_subbytes_serial.sv
// -----------------------------------------------------------------------------
// aes_subbytes_serial
// Substitutes all 16 bytes of an AES state through LANES S-box lanes over
// 16/LANES cycles. Both sides use a valid/ready handshake.
//   in_clk, in_rst     clock, synchronous active-high reset
//   in_req_valid       upstream state valid
//   out_req_ready      high in IDLE only
//   in_state    [128]  state to substitute, byte i = bits [8i+7:8i]
//   out_res_valid      high in DONE
//   in_res_ready       downstream accepts result
//   out_state   [128]  state register (meaningful when out_res_valid=1)
//   out_busy           high in BUSY and DONE
// Timing: accept edge counts as edge 1 and valid is seen after edge
// 16/LANES+1. The minimum period is 16/LANES+2 cycles.
// -----------------------------------------------------------------------------
module aes_subbytes_serial
  import aes_subbytes_serial_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic   in_clk,
  input  logic   in_rst,
  input  logic   in_req_valid,
  output logic   out_req_ready,
  input  bv128_t in_state,
  output logic   out_res_valid,
  input  logic   in_res_ready,
  output bv128_t out_state,
  output logic   out_busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_subbytes_serial: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int               STEPS    = 16 / LANES;
  localparam int               CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  subbytes_state_e   r_fsm;
  logic [CNT_W-1:0]  r_cnt;
  bv8_t [15:0]       r_state;
  logic              r_req_ready;
  logic              r_res_valid;
  logic              r_busy;

  logic [3:0]        w_byte_idx [LANES];
  bv8_t              w_sbox_out [LANES];

  // Lane l works on byte cnt*LANES + l, so lane 0 always holds the lowest byte.
  always_comb begin
    // NOTE: default every element first so no path leaves a combinational output unassigned (no latch).
    w_byte_idx = '{default: '0};
    for (int l = 0; l < LANES; l++) w_byte_idx[l] = 4'(int'(r_cnt) * LANES + l);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .i_byte (r_state[w_byte_idx[g]]),
      .o_byte (w_sbox_out[g])
    );
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_fsm       <= IDLE;
      r_cnt       <= '0;
      // NOTE: the state register is reset too, so out_state reads zero after reset and no aborted data leaks out.
      r_state     <= '0;
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_req_valid) begin
            r_state     <= in_state;
            r_cnt       <= '0;
            r_fsm       <= BUSY;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) r_state[w_byte_idx[l]] <= w_sbox_out[l];
          if (r_cnt == CNT_LAST) begin
            r_cnt       <= '0;
            r_fsm       <= DONE;
            r_res_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (in_res_ready) begin
            r_fsm       <= IDLE;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign out_req_ready = r_req_ready;
  assign out_res_valid = r_res_valid;
  assign out_busy      = r_busy;
  assign out_state     = r_state;

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// -----------------------------------------------------------------------------
// tb_aes_subbytes_serial
// Scoreboarded bench: an expected state is queued on every accepted request
// and compared when the result handshake happens. Expected values come from
// the FIPS-197 S-box table held locally.
// -----------------------------------------------------------------------------
module tb_aes_subbytes_serial;

  localparam int LANES  = 4;
  localparam int STEPS  = 16 / LANES;
  localparam int LAT    = STEPS + 1;
  localparam int PERIOD = STEPS + 2;
  localparam int BUDGET = 200;

  localparam logic [7:0] FIPS_SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

  logic         in_clk;
  logic         in_rst;
  logic         in_req_valid;
  logic         out_req_ready;
  logic [127:0] in_state;
  logic         out_res_valid;
  logic         in_res_ready;
  logic [127:0] out_state;
  logic         out_busy;

  aes_subbytes_serial #(.LANES(LANES)) dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_req_valid  (in_req_valid),
    .out_req_ready (out_req_ready),
    .in_state      (in_state),
    .out_res_valid (out_res_valid),
    .in_res_ready  (in_res_ready),
    .out_state     (out_state),
    .out_busy      (out_busy)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc      = 0;
  logic [127:0] sb_q [$];
  int           accept_cyc [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] sub_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = FIPS_SBOX[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  always @(posedge in_clk) cyc++;

  // Handshake signals are stable between #1 after one edge and the next edge,
  // so the falling edge sees exactly what the coming rising edge will sample.
  always @(negedge in_clk) begin
    if (in_rst) begin
      sb_q.delete();
    end else begin
      if (in_req_valid && out_req_ready) begin
        sb_q.push_back(sub_state(in_state));
        accept_cyc.push_back(cyc);
      end
      if (out_res_valid && in_res_ready) begin
        check("result_expected", 128'(sb_q.size() != 0), 128'd1);
        if (sb_q.size() != 0) check("out_state", out_state, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!out_req_ready && n < BUDGET) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 128'(out_req_ready), 128'd1);
  endtask

  // One transaction with the downstream always ready; returns the state seen with valid high.
  task automatic run_one(input logic [127:0] s, input string tag, output logic [127:0] got);
    int n;
    in_res_ready = 1'b1;
    wait_ready(tag);
    in_state     = s;
    in_req_valid = 1'b1;
    tick();
    in_req_valid = 1'b0;
    in_state     = rand128();
    n = 1;
    while (!out_res_valid && n < BUDGET) begin
      tick();
      n++;
    end
    got = out_state;
    check({tag, "_latency"}, 128'(n), 128'(LAT));
    tick();
    check({tag, "_valid_pulse"}, 128'(out_res_valid), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got;
    logic [127:0] exp;
    logic [127:0] vec;
    int           acc_base;
    int           n;

    in_rst       = 1'b1;
    in_req_valid = 1'b0;
    in_res_ready = 1'b0;
    in_state     = '0;
    repeat (3) tick();
    check("rst_req_ready", 128'(out_req_ready), 128'd1);
    check("rst_res_valid", 128'(out_res_valid), 128'd0);
    check("rst_busy",      128'(out_busy),      128'd0);
    check("rst_state",     out_state,           128'd0);
    in_rst = 1'b0;
    tick();

    // FIPS-197 appendix vector.
    run_one(FIPS_IN, "fips", got);
    check("fips_vector", got, FIPS_OUT);

    // Byte i = i: each byte must land back in its own slot.
    run_one(128'h0f0e0d0c0b0a09080706050403020100, "lanes", got);
    check("lanes_byte0",  128'(got[7:0]),     128'h63);
    check("lanes_byte1",  128'(got[15:8]),    128'h7c);
    check("lanes_byte15", 128'(got[127:120]), 128'h76);

    // Back-to-back: all 256 byte values, in_req_valid held high.
    in_res_ready = 1'b1;
    acc_base     = accept_cyc.size();
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) vec[8*i +: 8] = 8'(16 * k + i);
      in_state     = vec;
      in_req_valid = 1'b1;
      wait_ready("b2b");
      tick();
    end
    in_req_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < BUDGET) begin
      tick();
      n++;
    end
    check("b2b_drained", 128'(sb_q.size()), 128'd0);
    check("b2b_accepts", 128'(accept_cyc.size() - acc_base), 128'd16);
    for (int j = acc_base + 1; j < accept_cyc.size(); j++)
      check("b2b_period", 128'(accept_cyc[j] - accept_cyc[j-1]), 128'(PERIOD));

    // Backpressure: hold the result in DONE while upstream keeps poking.
    in_res_ready = 1'b0;
    wait_ready("bp");
    vec          = rand128();
    exp          = sub_state(vec);
    in_state     = vec;
    in_req_valid = 1'b1;
    tick();
    in_req_valid = 1'b0;
    n = 0;
    while (!out_res_valid && n < BUDGET) begin
      tick();
      n++;
    end
    check("bp_valid_rise", 128'(out_res_valid), 128'd1);
    acc_base = accept_cyc.size();
    for (int i = 0; i < 10; i++) begin
      in_req_valid = ~in_req_valid;
      in_state     = rand128();
      tick();
      check("bp_state_stable", out_state,           exp);
      check("bp_req_ready",    128'(out_req_ready), 128'd0);
      check("bp_valid_held",   128'(out_res_valid), 128'd1);
    end
    in_req_valid = 1'b0;
    check("bp_no_accept", 128'(accept_cyc.size() - acc_base), 128'd0);
    in_res_ready = 1'b1;
    tick();
    check("bp_release_valid", 128'(out_res_valid), 128'd0);
    check("bp_release_ready", 128'(out_req_ready), 128'd1);
    run_one(rand128(), "post_bp", got);

    // Reset in the middle of BUSY: the partial result must vanish.
    wait_ready("abort");
    in_state     = rand128();
    in_req_valid = 1'b1;
    tick();
    in_req_valid = 1'b0;
    repeat (STEPS / 2) tick();
    check("abort_busy_before", 128'(out_busy), 128'd1);
    in_rst = 1'b1;
    tick();
    in_rst = 1'b0;
    check("abort_busy",      128'(out_busy),      128'd0);
    check("abort_req_ready", 128'(out_req_ready), 128'd1);
    check("abort_state",     out_state,           128'd0);
    check("abort_res_valid", 128'(out_res_valid), 128'd0);
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      check("abort_no_result", 128'(out_res_valid), 128'd0);
    end
    run_one(128'd0, "zero", got);
    check("zero_all_63", got, {16{8'h63}});

    tick();
    check("final_drained", 128'(sb_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
